// File: rtl/calc_entry_ctrl.sv
// Key-entry controller for a two-operand calculator: collects decimal operands,
// drives a downstream ALU and captures its result.
module calc_entry_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic       key_is_op,
   input  logic [3:0] key_val,
   input  logic [7:0] alu_y,
   output logic [7:0] A,
   output logic [7:0] B,
   output logic [2:0] Sel,
   output logic [7:0] result,
   output logic       result_valid,
   output logic [7:0] disp,
   output logic       entry_err,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      COMPUTE = 2'd2,
      SHOW    = 2'd3
   } state_t;

   state_t      state_r;
   logic [11:0] acc_s;
   logic        is_digit_s;
   logic        is_oper_s;
   logic        is_equals_s;
   logic        is_clear_s;

   assign is_digit_s  = key_valid & ~key_is_op & (key_val <= 4'd9);
   assign is_oper_s   = key_valid &  key_is_op & ~key_val[3];
   assign is_equals_s = key_valid &  key_is_op & (key_val == 4'b1000);
   assign is_clear_s  = key_valid &  key_is_op & (key_val == 4'b1111);
   assign state       = state_r;

   // Candidate operand value: the one being entered times ten plus the new digit
   always_comb begin
      acc_s = 12'd0;
      if (state_r == ENTER_B) begin
         acc_s = ({4'd0, B} * 12'd10) + {8'd0, key_val};
      end else begin
         acc_s = ({4'd0, A} * 12'd10) + {8'd0, key_val};
      end
   end

   // Display follows the operand being typed, then the captured result
   always_comb begin
      disp = 8'd0;
      case (state_r)
         ENTER_A: disp = A;
         ENTER_B: disp = B;
         COMPUTE: disp = result;
         SHOW:    disp = result;
         default: disp = 8'd0;
      endcase
   end

   // Entry FSM; CLEAR is not honoured in COMPUTE because keys are dropped there
   always_ff @(posedge clk) begin
      if (rst || (is_clear_s && (state_r != COMPUTE))) begin
         state_r      <= ENTER_A;
         A            <= 8'd0;
         B            <= 8'd0;
         Sel          <= 3'b000;
         result       <= 8'd0;
         result_valid <= 1'b0;
         entry_err    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state_r)
            ENTER_A: begin
               if (is_digit_s) begin
                  if (acc_s > 12'd255) begin
                     entry_err <= 1'b1;
                  end else begin
                     A         <= acc_s[7:0];
                     entry_err <= 1'b0;
                  end
               end else if (is_oper_s) begin
                  Sel       <= key_val[2:0];
                  B         <= 8'd0;
                  entry_err <= 1'b0;
                  state_r   <= ENTER_B;
               end
            end
            ENTER_B: begin
               if (is_digit_s) begin
                  if (acc_s > 12'd255) begin
                     entry_err <= 1'b1;
                  end else begin
                     B         <= acc_s[7:0];
                     entry_err <= 1'b0;
                  end
               end else if (is_oper_s) begin
                  Sel       <= key_val[2:0];
                  entry_err <= 1'b0;
               end else if (is_equals_s) begin
                  entry_err <= 1'b0;
                  state_r   <= COMPUTE;
               end
            end
            COMPUTE: begin
               result       <= alu_y;
               result_valid <= 1'b1;
               state_r      <= SHOW;
            end
            SHOW: begin
               if (is_digit_s) begin
                  A         <= {4'd0, key_val};
                  B         <= 8'd0;
                  entry_err <= 1'b0;
                  state_r   <= ENTER_A;
               end else if (is_oper_s) begin
                  A         <= result;
                  B         <= 8'd0;
                  Sel       <= key_val[2:0];
                  entry_err <= 1'b0;
                  state_r   <= ENTER_B;
               end else if (is_equals_s) begin
                  A         <= result;
                  entry_err <= 1'b0;
                  state_r   <= COMPUTE;
               end
            end
            default: state_r <= ENTER_A;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios with literal
// expectations plus randomized keys compared every cycle against a reference model.
module tb_calc_entry_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic       key_is_op = 1'b0;
   logic [3:0] key_val = 4'd0;
   logic [7:0] alu_y;
   logic [7:0] A, B, result, disp;
   logic [2:0] Sel;
   logic       result_valid, entry_err;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // reference model state (plain integers)
   int m_ph, m_a, m_b, m_sel, m_res, m_rv, m_err;

   calc_entry_ctrl dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_is_op(key_is_op),
      .key_val(key_val), .alu_y(alu_y), .A(A), .B(B), .Sel(Sel),
      .result(result), .result_valid(result_valid), .disp(disp),
      .entry_err(entry_err), .state(state)
   );

   always #5 clk = ~clk;

   function automatic int alu(int a, int b, int s);
      case (s)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (a * b) % 256;
         6: return a / 2;
         default: return b;
      endcase
   endfunction

   assign alu_y = 8'(alu(int'(A), int'(B), int'(Sel)));

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void m_reset();
      m_ph = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_rv = 0; m_err = 0;
   endfunction

   // reference model, advanced on every rising edge
   always @(posedge clk) begin
      int v, n;
      v = int'(key_val);
      if (rst) m_reset();
      else if (m_ph == 2) begin
         m_res = alu(m_a, m_b, m_sel); m_rv = 1; m_ph = 3;
      end else begin
         m_rv = 0;
         if (key_valid && !key_is_op && v <= 9) begin
            if (m_ph == 3) begin
               m_a = v; m_b = 0; m_err = 0; m_ph = 0;
            end else begin
               n = (m_ph == 0 ? m_a : m_b) * 10 + v;
               if (n > 255) m_err = 1;
               else begin
                  if (m_ph == 0) m_a = n; else m_b = n;
                  m_err = 0;
               end
            end
         end else if (key_valid && key_is_op && v < 8) begin
            m_sel = v; m_err = 0;
            if (m_ph == 0) begin m_b = 0; m_ph = 1; end
            else if (m_ph == 3) begin m_a = m_res; m_b = 0; m_ph = 1; end
         end else if (key_valid && key_is_op && v == 8) begin
            if (m_ph == 1) begin m_ph = 2; m_err = 0; end
            else if (m_ph == 3) begin m_a = m_res; m_ph = 2; m_err = 0; end
         end else if (key_valid && key_is_op && v == 15) begin
            m_reset();
         end
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("state", int'(state), m_ph);
         check("A", int'(A), m_a);
         check("B", int'(B), m_b);
         check("Sel", int'(Sel), m_sel);
         check("result", int'(result), m_res);
         check("result_valid", int'(result_valid), m_rv);
         check("entry_err", int'(entry_err), m_err);
         check("disp", int'(disp), (m_ph == 0) ? m_a : (m_ph == 1) ? m_b : m_res);
      end
   end

   task automatic press(input logic op, input logic [3:0] v);
      @(negedge clk);
      key_valid = 1'b1; key_is_op = op; key_val = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         key_valid = 1'b0;
      end
   endtask

   task automatic check_cleared(string tag);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_A"}, int'(A), 0);
      check({tag, "_B"}, int'(B), 0);
      check({tag, "_Sel"}, int'(Sel), 0);
      check({tag, "_result"}, int'(result), 0);
      check({tag, "_rv"}, int'(result_valid), 0);
      check({tag, "_err"}, int'(entry_err), 0);
      check({tag, "_disp"}, int'(disp), 0);
   endtask

   localparam logic [3:0] EQ = 4'b1000;
   localparam logic [3:0] CLR = 4'b1111;

   initial begin
      idle(2);
      rst = 1'b0;
      chk_en = 1'b1;
      check_cleared("reset");

      // basic entry 12 + 34
      press(1'b0, 4'd1); press(1'b0, 4'd2); press(1'b1, 4'd0);
      press(1'b0, 4'd3); press(1'b0, 4'd4); idle(1);
      check("basic_A", int'(A), 12); check("basic_B", int'(B), 34);
      check("basic_Sel", int'(Sel), 0); check("basic_disp", int'(disp), 34);
      press(1'b1, EQ); idle(1);
      check("eq_state_compute", int'(state), 2); check("eq_rv_early", int'(result_valid), 0);
      idle(1);
      check("eq_result", int'(result), 46); check("eq_rv_pulse", int'(result_valid), 1);
      idle(1);
      check("eq_rv_end", int'(result_valid), 0); check("eq_state_show", int'(state), 3);

      // CLEAR from SHOW
      press(1'b1, CLR); idle(1);
      check_cleared("clear_show");

      // overflow, invalid keys, then boundary 255
      press(1'b0, 4'd2); press(1'b0, 4'd5); press(1'b0, 4'd6); idle(1);
      check("ovf_A", int'(A), 25); check("ovf_err", int'(entry_err), 1);
      press(1'b0, 4'hC); idle(1);
      check("bad_digit_A", int'(A), 25); check("bad_digit_err", int'(entry_err), 1);
      press(1'b1, 4'b1010); idle(1);
      check("bad_cmd_state", int'(state), 0); check("bad_cmd_err", int'(entry_err), 1);
      press(1'b1, EQ); idle(1);
      check("eq_in_entera", int'(state), 0);
      press(1'b0, 4'd5); idle(1);
      check("max_A", int'(A), 255); check("max_err", int'(entry_err), 0);

      // chaining from a result of 7
      press(1'b1, CLR); press(1'b0, 4'd3); press(1'b1, 4'd0); press(1'b0, 4'd4);
      press(1'b1, EQ); idle(2);
      check("chain_first", int'(result), 7);
      press(1'b1, 4'd1); press(1'b0, 4'd3); idle(1);
      check("chain_A", int'(A), 7); check("chain_B", int'(B), 3); check("chain_Sel", int'(Sel), 1);
      press(1'b1, EQ); idle(2);
      check("chain_result", int'(result), 4); check("chain_rv", int'(result_valid), 1);

      // repeat in SHOW with a digit dropped during COMPUTE
      idle(1);
      press(1'b1, EQ); press(1'b0, 4'd9); idle(1);
      check("rep_state", int'(state), 3); check("rep_A", int'(A), 4);
      check("rep_result", int'(result), 1); check("rep_rv", int'(result_valid), 1);

      // reset while entering B = 40
      press(1'b1, CLR); press(1'b0, 4'd1); press(1'b1, 4'd2);
      press(1'b0, 4'd4); press(1'b0, 4'd0); idle(1);
      check("rstb_B", int'(B), 40);
      rst = 1'b1; press(1'b0, 4'd7); idle(1); rst = 1'b0;
      check_cleared("rst_enterb");

      // reset during COMPUTE aborts the capture
      press(1'b0, 4'd5); press(1'b1, 4'd0); press(1'b0, 4'd6); press(1'b1, EQ);
      idle(1); rst = 1'b1; idle(1); rst = 1'b0;
      check("abort_result", int'(result), 0); check("abort_rv", int'(result_valid), 0);
      idle(1);
      check("abort_rv_after", int'(result_valid), 0);

      // randomized keys with occasional reset
      for (int i = 0; i < 3000; i++) begin
         int r;
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         key_valid = ($urandom_range(0, 9) < 6);
         key_is_op = ($urandom_range(0, 2) == 0);
         if (key_is_op) begin
            r = $urandom_range(0, 19);
            if (r < 10) key_val = 4'(r % 8);
            else if (r < 15) key_val = EQ;
            else if (r == 15) key_val = CLR;
            else key_val = 4'($urandom_range(9, 14));
         end else begin
            key_val = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
         end
      end
      rst = 1'b0;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
